// File: rtl/node_flag_collector.sv
// Windowed node-flag capture into a 2-entry result FIFO with sticky overflow.
// Optional popcount output enabled by NODE_FLAG_POPCOUNT_EN.
module node_flag_collector #(
    parameter int NUM_NODES = 16,
    parameter int WINDOW    = 5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_NODES-1:0]               node_flags,
    input  logic                               res_ready,
    output logic                               res_valid,
    output logic [NUM_NODES-1:0]               res_flags,
    output logic [$clog2(NUM_NODES+1)-1:0]     res_count,
    output logic                               res_any,
    output logic [2:0]                         win_cnt,
    output logic                               overflow
);
    localparam int         CW   = $clog2(NUM_NODES + 1);
    localparam logic [2:0] LAST = 3'(WINDOW - 1);

    logic [2:0]           win_q, win_d;
    logic [1:0]           occ_q, occ_d;
    logic                 ovf_q, ovf_d;
    logic [NUM_NODES-1:0] flg_q [2];
    logic [NUM_NODES-1:0] flg_d [2];
    logic                 any_q [2];
    logic                 any_d [2];
    logic                 cap, pop, full, head_v;

`ifdef NODE_FLAG_POPCOUNT_EN
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [CW-1:0] cap_cnt;

    always_comb begin
        cap_cnt = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            cap_cnt = cap_cnt + CW'(node_flags[i]);
        end
    end
`endif

    assign head_v = (occ_q != 2'd0);
    assign cap    = (win_q == LAST);
    assign pop    = head_v && res_ready;
    assign full   = (occ_q == 2'd2);

    always_comb begin
        win_d = cap ? 3'd0 : win_q + 3'd1;
        occ_d = occ_q;
        ovf_d = ovf_q;
        flg_d = flg_q;
        any_d = any_q;
`ifdef NODE_FLAG_POPCOUNT_EN
        cnt_d = cnt_q;
`endif
        // Shift-register FIFO: slot 0 is always the head.
        if (pop) begin
            flg_d[0] = flg_q[1];
            any_d[0] = any_q[1];
            flg_d[1] = '0;
            any_d[1] = 1'b0;
`ifdef NODE_FLAG_POPCOUNT_EN
            cnt_d[0] = cnt_q[1];
            cnt_d[1] = '0;
`endif
            occ_d = occ_q - 2'd1;
        end
        if (cap) begin
            if (full && !pop) begin
                ovf_d = 1'b1;
            end else if (occ_d == 2'd0) begin
                flg_d[0] = node_flags;
                any_d[0] = |node_flags;
`ifdef NODE_FLAG_POPCOUNT_EN
                cnt_d[0] = cap_cnt;
`endif
                occ_d = 2'd1;
            end else begin
                flg_d[1] = node_flags;
                any_d[1] = |node_flags;
`ifdef NODE_FLAG_POPCOUNT_EN
                cnt_d[1] = cap_cnt;
`endif
                occ_d = 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            win_q <= 3'd0;
            occ_q <= 2'd0;
            ovf_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                flg_q[i] <= '0;
                any_q[i] <= 1'b0;
`ifdef NODE_FLAG_POPCOUNT_EN
                cnt_q[i] <= '0;
`endif
            end
        end else begin
            win_q <= win_d;
            occ_q <= occ_d;
            ovf_q <= ovf_d;
            flg_q <= flg_d;
            any_q <= any_d;
`ifdef NODE_FLAG_POPCOUNT_EN
            cnt_q <= cnt_d;
`endif
        end
    end

    assign res_valid = rst && head_v;
    assign res_flags = res_valid ? flg_q[0] : '0;
    assign res_any   = res_valid && any_q[0];
`ifdef NODE_FLAG_POPCOUNT_EN
    assign res_count = res_valid ? cnt_q[0] : '0;
`else
    assign res_count = '0;
`endif
    assign win_cnt  = win_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_node_flag_collector.sv
// Scoreboard bench for node_flag_collector (NUM_NODES=16, WINDOW=5).
module tb_node_flag_collector;

    typedef struct {
        logic [15:0] f;
        logic [4:0]  c;
        logic        a;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] node_flags = '0;
    logic        res_ready = 1'b0;
    logic        res_valid;
    logic [15:0] res_flags;
    logic [4:0]  res_count;
    logic        res_any;
    logic [2:0]  win_cnt;
    logic        overflow;

    ent_t        q[$];
    int          phase_exp = 0;
    logic        ovf_exp = 1'b0;
    logic [4:0]  cur_c = '0;
    logic        cur_a = 1'b0;
    bit          started = 0;
    int          checks = 0;
    int          errors = 0;

    node_flag_collector #(.NUM_NODES(16), .WINDOW(5)) dut (
        .clk(clk),
        .rst(rst),
        .node_flags(node_flags),
        .res_ready(res_ready),
        .res_valid(res_valid),
        .res_flags(res_flags),
        .res_count(res_count),
        .res_any(res_any),
        .win_cnt(win_cnt),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference behaviour applied at each rising edge.
    task automatic step(input logic r, input logic rdy);
        bit popped;
        rst = r;
        res_ready = rdy;
        @(posedge clk);
        if (!r) begin
            q.delete();
            phase_exp = 0;
            ovf_exp = 1'b0;
        end else begin
            popped = rdy && (q.size() > 0);
            if (popped) void'(q.pop_front());
            if (phase_exp == 4) begin
                if (q.size() < 2) q.push_back('{node_flags, cur_c, cur_a});
                else ovf_exp = 1'b1;
            end
            phase_exp = (phase_exp == 4) ? 0 : phase_exp + 1;
        end
        #1;
    endtask

    task automatic win(input logic [15:0] f, input logic [4:0] c,
                       input logic a, input logic [4:0] rmask);
        node_flags = f;
        cur_c = c;
        cur_a = a;
        for (int p = 0; p < 5; p++) step(1'b1, rmask[p]);
    endtask

    always @(negedge clk) begin
        if (started) begin
            logic       ev;
            logic [4:0] ec;
            ev = rst && (q.size() > 0);
            chk("win_cnt", 32'(win_cnt), 32'(phase_exp));
            chk("overflow", 32'(overflow), 32'(ovf_exp));
            chk("res_valid", 32'(res_valid), 32'(ev));
            if (ev) begin
`ifdef NODE_FLAG_POPCOUNT_EN
                ec = q[0].c;
`else
                ec = 5'd0;
`endif
                chk("res_flags", 32'(res_flags), 32'(q[0].f));
                chk("res_count", 32'(res_count), 32'(ec));
                chk("res_any", 32'(res_any), 32'(q[0].a));
            end else begin
                chk("idle_flags", 32'(res_flags), 32'd0);
                chk("idle_count", 32'(res_count), 32'd0);
                chk("idle_any", 32'(res_any), 32'd0);
            end
        end
    end

    initial begin
        step(1'b0, 1'b0);
        started = 1;
        step(1'b0, 1'b1);
        win(16'h00F1, 5'd5, 1'b1, 5'b11111);
        win(16'h0000, 5'd0, 1'b0, 5'b11111);
        win(16'h0001, 5'd1, 1'b1, 5'b00000);
        win(16'h0003, 5'd2, 1'b1, 5'b00000);
        win(16'hA5A5, 5'd8, 1'b1, 5'b10000);
        win(16'h8000, 5'd1, 1'b1, 5'b00000);
        win(16'hFFFF, 5'd16, 1'b1, 5'b11111);
        win(16'h1234, 5'd5, 1'b1, 5'b11111);
        win(16'h7F00, 5'd7, 1'b1, 5'b00000);
        node_flags = 16'hBEEF;
        for (int p = 0; p < 3; p++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        win(16'h00F1, 5'd5, 1'b1, 5'b00000);
        win(16'hFFFF, 5'd16, 1'b1, 5'b11111);
        for (int p = 0; p < 5; p++) step(1'b1, 1'b1);
        started = 0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/node_flag_collector.md
NODE_FLAG_COLLECTOR -- requirements
Module: node_flag_collector

Interface
REQ-001 The block SHALL have parameter NUM_NODES, default 16, giving the number of node flag inputs (1..64).
REQ-002 The block SHALL have parameter WINDOW, default 5, giving the evaluation-window length in cycles (2..8).
REQ-003 The block SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port node_flags  input  NUM_NODES  per-node accumulated flag outputs.
REQ-006 The block SHALL have port res_ready  input  1  downstream accept.
REQ-007 The block SHALL have port res_valid  output  1  result available at FIFO head.
REQ-008 The block SHALL have port res_flags  output  NUM_NODES  captured flag vector at FIFO head.
REQ-009 The block SHALL have port res_count  output  clog2(NUM_NODES+1)  number of set bits in res_flags.
REQ-010 The block SHALL have port res_any  output  1  OR of res_flags.
REQ-011 The block SHALL have port win_cnt  output  3  current window phase.
REQ-012 The block SHALL have port overflow  output  1  sticky; a capture was dropped.

Function
REQ-013 win_cnt SHALL count 0,1,...,WINDOW-1, then wrap to 0, advancing once per cycle after reset.
REQ-014 In the cycle where win_cnt == WINDOW-1, the block SHALL capture node_flags and push one entry into a 2-entry FIFO.
REQ-015 A FIFO entry SHALL be {flags, popcount, any}, with popcount and any computed from the captured flags at capture time.
REQ-016 res_valid SHALL be 1 exactly when the FIFO is non-empty.
REQ-017 res_flags, res_count and res_any SHALL show the head entry and SHALL hold stable while res_valid=1 and res_ready=0.
REQ-018 A pop SHALL occur on a cycle with res_valid=1 and res_ready=1; the next entry, if any, SHALL appear on the following cycle.
REQ-019 When a capture and a pop occur in the same cycle with the FIFO full, both SHALL complete, no data SHALL be lost, and occupancy SHALL stay 2.
REQ-020 When a capture occurs with the FIFO full and no pop, the new entry SHALL be dropped, FIFO contents SHALL be unchanged, and overflow SHALL be set.
REQ-021 A capture into an empty FIFO SHALL make res_valid=1 on the next cycle; capture-to-valid latency is 1 cycle.
REQ-022 res_ready SHALL be ignored while res_valid=0.
REQ-023 When res_valid=0, res_flags, res_count and res_any SHALL read 0.

Reset
REQ-024 While rst=0 at a rising edge, the block SHALL clear win_cnt, FIFO occupancy, all FIFO entries and overflow to 0.
REQ-025 While rst=0, res_valid, res_flags, res_count and res_any SHALL all be 0.
REQ-026 The first cycle with rst=1 SHALL be phase 0, so the first capture occurs WINDOW-1 cycles after reset release, aligned with the upstream node windows.
REQ-027 A reset asserted mid-window or with results pending SHALL discard all pending results without emitting them.
REQ-028 Clearing overflow SHALL require reset.

Configuration
REQ-029 Macro NODE_FLAG_POPCOUNT_EN: when defined, res_count SHALL be the registered popcount per REQ-015; when undefined, no popcount logic SHALL be built, res_count SHALL be constant 0, and res_any SHALL be unaffected.

Verification
REQ-030 Verification SHALL use NUM_NODES=16, WINDOW=5, NODE_FLAG_POPCOUNT_EN defined unless stated.
REQ-031 Scenario: reset released, node_flags=16'h00F1, res_ready=1 -> capture at win_cnt=4; next cycle res_valid=1 for one cycle, res_flags=16'h00F1, res_count=5, res_any=1.
REQ-032 Scenario: res_ready=0, flags 16'h0001 then 16'h0003 over two windows -> occupancy 2, head 16'h0001 held stable; third capture sets overflow=1 and head remains 16'h0001.
REQ-033 Scenario: FIFO full, res_ready=1 exactly on a win_cnt=4 cycle -> 16'h0001 popped, new entry accepted, overflow stays 0, next head 16'h0003.
REQ-034 Scenario: node_flags=16'h0000 -> res_valid=1, res_count=0, res_any=0.
REQ-035 Scenario: rst=0 at win_cnt=2 with one pending entry -> res_valid=0 next cycle; after release, first capture occurs 4 cycles later.
REQ-036 Scenario: NODE_FLAG_POPCOUNT_EN undefined, flags 16'hFFFF -> res_count=0, res_any=1, res_flags=16'hFFFF.
